// File: rtl/risc32_pkg.sv
// Shared architectural constants for the RV32 hazard scoreboard.
// Counter width is derived from the writeback latency.
package risc32_pkg;

  localparam int NREG   = 32;
  localparam int ADDR_W = 5;
  localparam int WB_LAT = 2;

  function automatic int cnt_w(input int lat);
    return $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/risc_sb_counter.sv
// Per-register pending-write counter: load on issue, drain by one per
// cycle, cleared by flush or reset.
import risc32_pkg::*;

module risc_sb_counter #(
  parameter int LAT = WB_LAT,
  parameter int CW  = cnt_w(LAT)
) (
  input  logic clk1,
  input  logic rst,
  input  logic load,
  input  logic flush,
  output logic busy
);

  logic [CW-1:0] cnt;

  // Load wins over the drain so a rewrite restarts the full latency.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(LAT);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/risc_hazard_scoreboard.sv
// RAW hazard scoreboard: stalls issue while a source register still
// has a write in flight, and counts the stall cycles.
module risc_hazard_scoreboard #(
  parameter int NREG    = risc32_pkg::NREG,
  parameter int ADDR_W  = risc32_pkg::ADDR_W,
  parameter int WB_LAT  = risc32_pkg::WB_LAT,
  parameter int STALL_W = 16
) (
  input  logic               clk1,
  input  logic               rst,
  input  logic               issue_valid,
  output logic               issue_ready,
  input  logic [ADDR_W-1:0]  rs_addr,
  input  logic [ADDR_W-1:0]  rt_addr,
  input  logic               rs_used,
  input  logic               rt_used,
  input  logic [ADDR_W-1:0]  rd_addr,
  input  logic               rd_we,
  input  logic               halted,
  input  logic               flush,
  output logic [NREG-1:0]    busy_mask,
  output logic [STALL_W-1:0] stall_count
);

  localparam int CW = risc32_pkg::cnt_w(WB_LAT);

  logic            hazard;
  logic            accept;
  logic [NREG-1:1] load;

  // Sources are checked against the state before this instruction's load.
  always_comb begin
    hazard = 1'b0;
    if (rs_used && rs_addr != '0 && busy_mask[rs_addr])
      hazard = 1'b1;
    if (rt_used && rt_addr != '0 && busy_mask[rt_addr])
      hazard = 1'b1;
  end

  assign issue_ready = !hazard && !halted && !flush;
  assign accept      = issue_valid && issue_ready;

  always_comb begin
    load = '0;
    if (accept && rd_we && rd_addr != '0)
      load[rd_addr] = 1'b1;
  end

  assign busy_mask[0] = 1'b0;

  for (genvar i = 1; i < NREG; i++) begin : g_reg
    risc_sb_counter #(
      .LAT(WB_LAT),
      .CW (CW)
    ) u_cnt (
      .clk1 (clk1),
      .rst  (rst),
      .load (load[i]),
      .flush(flush),
      .busy (busy_mask[i])
    );
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if (issue_valid && hazard && !halted && !flush
                 && stall_count != '1) begin
      stall_count <= stall_count + STALL_W'(1);
    end
  end

endmodule

// File: tb/tb_risc_hazard_scoreboard.sv
// Bench for risc_hazard_scoreboard: directed scenarios plus random
// traffic against a ready-time model of register availability.
module tb_risc_hazard_scoreboard;

  localparam int NREG   = 32;
  localparam int ADDR_W = 5;
  localparam int WB_LAT = 2;

  logic              clk1 = 1'b0;
  logic              rst  = 1'b1;
  logic              issue_valid = 1'b0;
  logic [ADDR_W-1:0] rs_addr = '0;
  logic [ADDR_W-1:0] rt_addr = '0;
  logic              rs_used = 1'b0;
  logic              rt_used = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic              rd_we = 1'b0;
  logic              halted = 1'b0;
  logic              flush = 1'b0;

  logic              ready16, ready4;
  logic [NREG-1:0]   busy16, busy4;
  logic [15:0]       stall16;
  logic [3:0]        stall4;

  always #5 clk1 = ~clk1;

  risc_hazard_scoreboard #(.STALL_W(16)) dut (
    .clk1(clk1), .rst(rst), .issue_valid(issue_valid),
    .issue_ready(ready16), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_used(rs_used), .rt_used(rt_used), .rd_addr(rd_addr),
    .rd_we(rd_we), .halted(halted), .flush(flush),
    .busy_mask(busy16), .stall_count(stall16)
  );

  risc_hazard_scoreboard #(.STALL_W(4)) dut4 (
    .clk1(clk1), .rst(rst), .issue_valid(issue_valid),
    .issue_ready(ready4), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_used(rs_used), .rt_used(rt_used), .rd_addr(rd_addr),
    .rd_we(rd_we), .halted(halted), .flush(flush),
    .busy_mask(busy4), .stall_count(stall4)
  );

  int errors = 0;
  int checks = 0;

  // Model: register r is readable from cycle ready_at[r] onward.
  longint cyc = 0;
  longint ready_at [NREG];
  int     exp_stall = 0;

  function automatic bit m_busy(input int r);
    return (r != 0) && (cyc < ready_at[r]);
  endfunction

  function automatic bit m_hazard();
    return (rs_used && m_busy(int'(rs_addr))) ||
           (rt_used && m_busy(int'(rt_addr)));
  endfunction

  function automatic bit m_ready();
    return !m_hazard() && !halted && !flush;
  endfunction

  function automatic logic [NREG-1:0] m_mask();
    logic [NREG-1:0] m;
    m = '0;
    for (int r = 0; r < NREG; r++) m[r] = m_busy(r);
    return m;
  endfunction

  function automatic int sat15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) ready_at[r] = 0;
    exp_stall = 0;
  endtask

  task automatic step();
    bit acc;
    bit haz;
    @(posedge clk1);
    haz = m_hazard();
    acc = issue_valid && m_ready();
    if (issue_valid && haz && !halted && !flush) exp_stall++;
    if (flush) begin
      for (int r = 0; r < NREG; r++) ready_at[r] = 0;
    end else if (acc && rd_we && rd_addr != '0) begin
      ready_at[rd_addr] = cyc + WB_LAT + 1;
    end
    cyc++;
    #1;
  endtask

  task automatic drive(input bit v, input int rs, input bit rsu,
                       input int rt, input bit rtu,
                       input int rd, input bit we);
    issue_valid = v;
    rs_addr = ADDR_W'(rs);
    rs_used = rsu;
    rt_addr = ADDR_W'(rt);
    rt_used = rtu;
    rd_addr = ADDR_W'(rd);
    rd_we   = we;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk1);
    halted = 1'b0;
    flush  = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1, 1, 1, 2, 1, 3, 1);
    checks++;
    if (busy16 !== '0) begin
      errors++;
      $display("FAIL reset_busy: got %h want 0", busy16);
    end
    checks++;
    if (stall16 !== 16'd0) begin
      errors++;
      $display("FAIL reset_stall: got %0d want 0", stall16);
    end
    checks++;
    if (ready16 !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", ready16);
    end
    @(negedge clk1);
    rst = 1'b0;
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_raw();
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 1);
    checks++;
    if (ready16 !== 1'b1) begin
      errors++;
      $display("FAIL raw_producer: got %b want 1", ready16);
    end
    step();
    drive(1, 1, 1, 2, 1, 4, 1);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ready16 !== (k == 2)) begin
        errors++;
        $display("FAIL raw_ready[%0d]: got %b want %b", k, ready16, k == 2);
      end
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (stall16 !== 16'd2) begin
      errors++;
      $display("FAIL raw_stalls: got %0d want 2", stall16);
    end
    checks++;
    if (busy16[4] !== 1'b1) begin
      errors++;
      $display("FAIL raw_r4_busy: got %b want 1", busy16[4]);
    end
  endtask

  task automatic test_r0();
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 1);
    step();
    drive(1, 0, 1, 0, 1, 6, 0);
    checks++;
    if (busy16 !== '0) begin
      errors++;
      $display("FAIL r0_busy: got %h want 0", busy16);
    end
    checks++;
    if (ready16 !== 1'b1) begin
      errors++;
      $display("FAIL r0_ready: got %b want 1", ready16);
    end
    step();
    checks++;
    if (stall16 !== 16'd0) begin
      errors++;
      $display("FAIL r0_stalls: got %0d want 0", stall16);
    end
  endtask

  task automatic test_flush();
    do_reset();
    drive(1, 0, 0, 0, 0, 3, 1);
    step();
    checks++;
    if (busy16[3] !== 1'b1) begin
      errors++;
      $display("FAIL flush_pre_busy: got %b want 1", busy16[3]);
    end
    flush = 1'b1;
    drive(1, 3, 1, 0, 0, 8, 1);
    checks++;
    if (ready16 !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready: got %b want 0", ready16);
    end
    step();
    flush = 1'b0;
    drive(1, 3, 1, 3, 1, 0, 0);
    checks++;
    if (busy16 !== '0) begin
      errors++;
      $display("FAIL flush_busy: got %h want 0", busy16);
    end
    checks++;
    if (ready16 !== 1'b1) begin
      errors++;
      $display("FAIL flush_reader: got %b want 1", ready16);
    end
    step();
    checks++;
    if (stall16 !== 16'd0) begin
      errors++;
      $display("FAIL flush_stalls: got %0d want 0", stall16);
    end
  endtask

  task automatic test_reload();
    do_reset();
    drive(1, 0, 0, 0, 0, 3, 1);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    drive(1, 0, 0, 0, 0, 3, 1);
    checks++;
    if (ready16 !== 1'b1) begin
      errors++;
      $display("FAIL reload_accept: got %b want 1", ready16);
    end
    step();
    drive(1, 3, 1, 0, 0, 9, 0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ready16 !== (k == 2) || busy16[3] !== (k != 2)) begin
        errors++;
        $display("FAIL reload[%0d]: got ready=%b busy=%b want ready=%b busy=%b",
                 k, ready16, busy16[3], k == 2, k != 2);
      end
      step();
    end
  endtask

  task automatic test_halt();
    do_reset();
    drive(1, 0, 0, 0, 0, 7, 1);
    step();
    halted = 1'b1;
    drive(1, 7, 1, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ready16 !== 1'b0 || busy16[7] !== (k < 2)) begin
        errors++;
        $display("FAIL halt[%0d]: got ready=%b busy=%b want ready=0 busy=%b",
                 k, ready16, busy16[7], k < 2);
      end
      step();
    end
    halted = 1'b0;
    #1;
    checks++;
    if (ready16 !== 1'b1 || stall16 !== 16'd0) begin
      errors++;
      $display("FAIL halt_release: got ready=%b stalls=%0d want ready=1 stalls=0",
               ready16, stall16);
    end
    step();
  endtask

  task automatic test_saturation();
    do_reset();
    drive(1, 5, 1, 0, 0, 5, 1);
    for (int k = 0; k < 30; k++) step();
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (stall16 !== 16'd20) begin
      errors++;
      $display("FAIL sat_wide: got %0d want 20", stall16);
    end
    checks++;
    if (stall4 !== 4'd15) begin
      errors++;
      $display("FAIL sat_narrow: got %0d want 15", stall4);
    end
  endtask

  task automatic test_async_reset();
    time t0;
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 1);
    step();
    drive(1, 1, 1, 0, 0, 2, 1);
    step();
    checks++;
    if (stall16 !== 16'd1 || busy16[1] !== 1'b1) begin
      errors++;
      $display("FAIL arst_pre: got stalls=%0d busy=%b want 1 1",
               stall16, busy16[1]);
    end
    t0 = $time;
    rst = 1'b1;
    #1;
    checks++;
    if (busy16 !== '0 || stall16 !== 16'd0 || stall4 !== 4'd0) begin
      errors++;
      $display("FAIL arst_clear: got busy=%h stalls=%0d/%0d want 0",
               busy16, stall16, stall4);
    end
    checks++;
    if (ready16 !== 1'b1 || ($time - t0) >= 4) begin
      errors++;
      $display("FAIL arst_ready: got %b want 1", ready16);
    end
    halted = 1'b1;
    #1;
    checks++;
    if (ready16 !== 1'b0) begin
      errors++;
      $display("FAIL arst_halted: got %b want 0", ready16);
    end
    halted = 1'b0;
    model_reset();
    @(negedge clk1);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      flush  = ($urandom_range(0, 11) == 0);
      halted = ($urandom_range(0, 9) == 0);
      drive($urandom_range(0, 3) != 0,
            $urandom_range(0, 7), $urandom_range(0, 1) == 1,
            $urandom_range(0, 7), $urandom_range(0, 1) == 1,
            $urandom_range(0, 7), $urandom_range(0, 3) != 0);
      checks++;
      if (ready16 !== m_ready() || ready4 !== m_ready()) begin
        errors++;
        $display("FAIL rnd_ready[%0d]: got %b/%b want %b",
                 n, ready16, ready4, m_ready());
      end
      checks++;
      if (busy16 !== m_mask()) begin
        errors++;
        $display("FAIL rnd_busy[%0d]: got %h want %h", n, busy16, m_mask());
      end
      checks++;
      if (stall16 !== 16'(exp_stall) || stall4 !== 4'(sat15(exp_stall))) begin
        errors++;
        $display("FAIL rnd_stalls[%0d]: got %0d/%0d want %0d/%0d",
                 n, stall16, stall4, exp_stall, sat15(exp_stall));
      end
      step();
    end
    flush  = 1'b0;
    halted = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_raw();
    test_r0();
    test_flush();
    test_reload();
    test_halt();
    test_saturation();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/risc_hazard_scoreboard.md
RISC_HAZARD_SCOREBOARD -- requirements
Module: risc_hazard_scoreboard

Interface
REQ-001 Parameter NREG, default 32: number of architectural registers; register 0 is hard-wired zero.
REQ-002 Parameter ADDR_W, default 5: register address width; ADDR_W SHALL equal clog2(NREG).
REQ-003 Parameter WB_LAT, default 2, legal range 1..15: bubble cycles required between a producer and its dependent consumer.
REQ-004 Parameter STALL_W, default 16: stall counter width.
REQ-005 clk1  in  1  sole clock; all state updates on the rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 issue_valid  in  1  decoder presents an instruction this cycle.
REQ-008 issue_ready  out  1  instruction may issue; combinational.
REQ-009 rs_addr, rt_addr  in  ADDR_W each  source register addresses.
REQ-010 rs_used, rt_used  in  1 each  the corresponding source is read.
REQ-011 rd_addr  in  ADDR_W  destination register address.
REQ-012 rd_we  in  1  instruction writes rd.
REQ-013 halted  in  1  processor halted; blocks issue.
REQ-014 flush  in  1  taken branch; all in-flight writes are cancelled.
REQ-015 busy_mask  out  NREG  bit i high when register i has a pending write.
REQ-016 stall_count  out  STALL_W  saturating count of hazard stall cycles.

Function
REQ-017 Each register i SHALL have a pending counter cnt[i] of width clog2(WB_LAT+1); busy_mask[i] = (cnt[i] != 0).
REQ-018 Hazard = (rs_used and rs_addr != 0 and cnt[rs_addr] != 0) or (rt_used and rt_addr != 0 and cnt[rt_addr] != 0).
REQ-019 issue_ready = not hazard and not halted and not flush.
REQ-020 Accept = issue_valid and issue_ready; on an accepting edge with rd_we = 1 and rd_addr != 0, cnt[rd_addr] SHALL load WB_LAT.
REQ-021 Every other nonzero cnt[i] SHALL decrement by 1 per edge; a load to the same register in the same cycle SHALL take precedence over the decrement.
REQ-022 Latency: a producer accepted at edge E0 SHALL allow a dependent consumer to be accepted no earlier than edge E(WB_LAT+1), giving exactly WB_LAT stall cycles.
REQ-023 Writes to register 0 SHALL never set busy; cnt[0] SHALL remain 0.
REQ-024 flush = 1 SHALL clear every cnt[i] to 0 at the edge and SHALL force issue_ready low that cycle; flush SHALL override a simultaneous issue.
REQ-025 halted = 1 SHALL hold issue_ready low while counters continue draining.
REQ-026 stall_count SHALL increment on each edge where issue_valid = 1, hazard = 1, halted = 0 and flush = 0, and SHALL saturate at 2^STALL_W - 1.
REQ-027 An instruction whose rd equals one of its own sources SHALL be checked against the state before its own load.

Reset
REQ-028 rst = 1 SHALL immediately clear all cnt[i], busy_mask and stall_count to 0, regardless of clk1.
REQ-029 Reset asserted mid-stall SHALL drop the hazard; issue_ready SHALL then depend only on halted and flush.

Structure
REQ-030 NREG, ADDR_W and the WB_LAT default SHALL live in the shared package risc32_pkg.
REQ-031 The per-register load/decrement counter SHALL be the sub-module risc_sb_counter, instantiated NREG-1 times by a generate loop.

Verification
REQ-032 Issue ADDI r1 (rd = 1), then present ADD r4 = r1 + r2 continuously -> issue_ready low for 2 cycles, ADD accepted on the third edge, stall_count = 2.
REQ-033 Issue a write to r0, then a reader of r0 -> no stall, busy_mask = 0.
REQ-034 Issue a write to r3, assert flush on the next cycle -> busy_mask = 0 after that edge; a reader of r3 issues with no stall.
REQ-035 r3 at cnt = 1 while a new write to r3 is accepted -> cnt[3] = 2; a dependent reader stalls 2 more cycles.
REQ-036 With STALL_W = 4, hold a hazard for 20 cycles -> stall_count saturates at 15.
REQ-037 Assert rst asynchronously while r1 is busy -> busy_mask and stall_count go to 0 before the next clk1 edge.
